writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/wb_pkg.sv | 60 ++++++
 rtl/writeback_stage_if.sv | 46 ++++
 rtl/load_align.sv | 36 +++
 rtl/writeback_stage.sv | 87 ++++++++
 tb/tb_writeback_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, result-source
// indices, load-size enum and the load-control decode.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_LOAD = 1;
  localparam int unsigned SRC_PC4  = 2;

  // Access width is 8 << size bits
  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_DWORD = 2'd3
  } load_size_e;

  typedef struct packed {
    logic       known;
    logic       sext;
    load_size_e size;
  } load_ctl_t;

  // Doubleword and unsigned-word loads only exist on a 64-bit datapath
  function automatic load_ctl_t decode_load(input logic [2:0] funct3, input int unsigned xlen);
    load_ctl_t ctl;
    ctl.known = 1'b1;
    ctl.sext  = 1'b1;
    ctl.size  = LS_BYTE;
    case (funct3)
      F3_LB:  ctl.size = LS_BYTE;
      F3_LH:  ctl.size = LS_HALF;
      F3_LW:  ctl.size = LS_WORD;
      F3_LBU: ctl.sext = 1'b0;
      F3_LHU: begin
        ctl.sext = 1'b0;
        ctl.size = LS_HALF;
      end
      F3_LD: begin
        ctl.size  = LS_DWORD;
        ctl.known = (xlen == 64);
      end
      F3_LWU: begin
        ctl.sext  = 1'b0;
        ctl.size  = LS_WORD;
        ctl.known = (xlen == 64);
      end
      default: ctl.known = 1'b0;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->W bus of the writeback stage. RetireCnt exists only when
// WB_RETIRE_CNT_EN is defined.
interface writeback_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned REG_AW  = 5
);
  localparam int unsigned SW   = $clog2(NUM_SRC);
  localparam int unsigned LSBW = $clog2(XLEN/8);

  logic                    ValidM;
  logic                    StallW;
  logic                    FlushW;
  logic                    RegWriteM;
  logic [SW-1:0]           ResultSrcM;
  logic [NUM_SRC*XLEN-1:0] SrcDataM;
  logic [REG_AW-1:0]       RdM;
  logic [2:0]              LoadFunct3M;
  logic [LSBW-1:0]         AddrLsbM;

  logic                    ValidW;
  logic                    RegWriteW;
  logic [REG_AW-1:0]       RdW;
  logic [XLEN-1:0]         ResultW;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]             RetireCnt;

  modport master (
    output ValidM, StallW, FlushW, RegWriteM, ResultSrcM, SrcDataM, RdM, LoadFunct3M, AddrLsbM,
    input  ValidW, RegWriteW, RdW, ResultW, RetireCnt
  );
  modport slave (
    input  ValidM, StallW, FlushW, RegWriteM, ResultSrcM, SrcDataM, RdM, LoadFunct3M, AddrLsbM,
    output ValidW, RegWriteW, RdW, ResultW, RetireCnt
  );
`else
  modport master (
    output ValidM, StallW, FlushW, RegWriteM, ResultSrcM, SrcDataM, RdM, LoadFunct3M, AddrLsbM,
    input  ValidW, RegWriteW, RdW, ResultW
  );
  modport slave (
    input  ValidM, StallW, FlushW, RegWriteM, ResultSrcM, SrcDataM, RdM, LoadFunct3M, AddrLsbM,
    output ValidW, RegWriteW, RdW, ResultW
  );
`endif
endinterface

// File: rtl/load_align.sv
// Combinational load-data alignment: lane shift, size extract, sign/zero extend.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]          data,
  input  logic [2:0]               funct3,
  input  logic [$clog2(XLEN/8)-1:0] addr_lsb,
  output logic [XLEN-1:0]          aligned_c
);
  localparam int unsigned LSBW = $clog2(XLEN/8);

  load_ctl_t              ctl;
  logic [LSBW-1:0]        lsb_eff;
  logic [XLEN-1:0]        lane;
  logic [XLEN-1:0]        left;
  logic signed [XLEN-1:0] sext;
  int unsigned            pad;

  // Push the field to the top, then shift back arithmetically or logically
  always_comb begin
    ctl       = decode_load(funct3, XLEN);
    lsb_eff   = addr_lsb & ~LSBW'((32'd1 << ctl.size) - 32'd1);
    lane      = data >> {lsb_eff, 3'b000};
    pad       = XLEN - (32'd8 << ctl.size);
    left      = lane << pad;
    sext      = $signed(left) >>> pad;
    aligned_c = data;
    if (ctl.known) begin
      if (ctl.sext) aligned_c = $unsigned(sext);
      else          aligned_c = left >> pad;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: W pipeline register, load alignment and result select.
// Optional retired-instruction counter under WB_RETIRE_CNT_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned REG_AW  = 5
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave bus
);
  localparam int unsigned SW   = $clog2(NUM_SRC);
  localparam int unsigned LSBW = $clog2(XLEN/8);

  if (NUM_SRC <= SRC_PC4) begin : g_num_src_check
    $error("writeback_stage: NUM_SRC must be at least 3");
  end

  logic                    valid_q;
  logic                    regwrite_q;
  logic [SW-1:0]           src_q;
  logic [NUM_SRC*XLEN-1:0] data_q;
  logic [REG_AW-1:0]       rd_q;
  logic [2:0]              funct3_q;
  logic [LSBW-1:0]         lsb_q;
  logic [XLEN-1:0]         load_c;
  logic [XLEN-1:0]         result_c;

  // x0 suppression folded into the captured write enable
  always_ff @(posedge clk) begin
    if (reset || bus.FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      lsb_q      <= '0;
    end else if (!bus.StallW) begin
      valid_q    <= bus.ValidM;
      regwrite_q <= bus.ValidM && bus.RegWriteM && (bus.RdM != '0);
      src_q      <= bus.ResultSrcM;
      data_q     <= bus.SrcDataM;
      rd_q       <= bus.RdM;
      funct3_q   <= bus.LoadFunct3M;
      lsb_q      <= bus.AddrLsbM;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .data      (data_q[SRC_LOAD*XLEN +: XLEN]),
    .funct3    (funct3_q),
    .addr_lsb  (lsb_q),
    .aligned_c (load_c)
  );

  // Bubbles and out-of-range selects read as zero
  always_comb begin
    result_c = '0;
    if (valid_q) begin
      if (int'(src_q) == SRC_LOAD)    result_c = load_c;
      else if (int'(src_q) < NUM_SRC) result_c = data_q[int'(src_q)*XLEN +: XLEN];
    end
  end

  assign bus.ValidW    = valid_q;
  assign bus.RegWriteW = regwrite_q;
  assign bus.RdW       = rd_q;
  assign bus.ResultW   = result_c;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
    end else if (valid_q && !bus.StallW && !bus.FlushW) begin
      retire_q <= retire_q + 64'd1;
    end
  end

  assign bus.RetireCnt = retire_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_writeback_stage;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned REG_AW  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) bus ();

  writeback_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model of what the W stage must present
  logic            m_valid  = 1'b0;
  logic            m_we     = 1'b0;
  logic [4:0]      m_rd     = '0;
  logic [31:0]     m_result = '0;
  longint unsigned m_cnt    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input int unsigned lsb);
    logic [31:0] r;
    int unsigned off;
    case (f3)
      3'd0, 3'd4: begin
        r = (w >> (8 * lsb)) & 32'h0000_00FF;
        if (f3 == 3'd0 && r[7]) r = r | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        off = lsb & 2;
        r = (w >> (8 * off)) & 32'h0000_FFFF;
        if (f3 == 3'd1 && r[15]) r = r | 32'hFFFF_0000;
      end
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_result(input logic v, input logic [1:0] src,
                                             input logic [127:0] d, input logic [2:0] f3,
                                             input logic [1:0] lsb);
    if (!v) return 32'h0;
    if (src == 2'd1) return ref_load(d[63:32], f3, int'(lsb));
    return d[32*src +: 32];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0; m_we = 1'b0; m_rd = '0; m_result = '0; m_cnt = 0;
    end else begin
      if (m_valid && !bus.StallW && !bus.FlushW) m_cnt = m_cnt + 1;
      if (bus.FlushW) begin
        m_valid = 1'b0; m_we = 1'b0; m_rd = '0; m_result = '0;
      end else if (!bus.StallW) begin
        m_valid  = bus.ValidM;
        m_we     = bus.ValidM && bus.RegWriteM && (bus.RdM != 5'd0);
        m_rd     = bus.RdM;
        m_result = ref_result(bus.ValidM, bus.ResultSrcM, bus.SrcDataM,
                              bus.LoadFunct3M, bus.AddrLsbM);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model ValidW", 64'(bus.ValidW), 64'(m_valid));
      chk("model RegWriteW", 64'(bus.RegWriteW), 64'(m_we));
      chk("model RdW", 64'(bus.RdW), 64'(m_rd));
      chk("model ResultW", 64'(bus.ResultW), 64'(m_result));
`ifdef WB_RETIRE_CNT_EN
      chk("model RetireCnt", bus.RetireCnt, m_cnt);
`endif
    end
  end

  task automatic drive(input logic v, input logic we, input logic [1:0] src, input logic [2:0] f3,
                       input logic [1:0] lsb, input logic [4:0] rd, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    bus.ValidM      = v;
    bus.RegWriteM   = we;
    bus.ResultSrcM  = src;
    bus.LoadFunct3M = f3;
    bus.AddrLsbM    = lsb;
    bus.RdM         = rd;
    bus.SrcDataM    = {d3, d2, d1, d0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] exp,
                           input string name);
    drive(1'b1, 1'b1, 2'd1, f3, lsb, 5'd6, 32'h0, 32'h80FF_7F00, 32'h0, 32'h0);
    step();
    chk(name, 64'(bus.ResultW), 64'(exp));
  endtask

  initial begin
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    cmp_en = 1'b1;
    step();
    chk("reset ValidW", 64'(bus.ValidW), 64'd0);
    chk("reset RegWriteW", 64'(bus.RegWriteW), 64'd0);
    chk("reset RdW", 64'(bus.RdW), 64'd0);
    chk("reset ResultW", 64'(bus.ResultW), 64'd0);
    reset = 1'b0;

    // ALU capture
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
    step();
    chk("alu ResultW", 64'(bus.ResultW), 64'h1234_5678);
    chk("alu RdW", 64'(bus.RdW), 64'd5);
    chk("alu RegWriteW", 64'(bus.RegWriteW), 64'd1);

    // Load alignment
    load_case(3'd0, 2'd1, 32'h0000_007F, "lb lsb1");
    load_case(3'd0, 2'd3, 32'hFFFF_FF80, "lb lsb3");
    load_case(3'd5, 2'd2, 32'h0000_80FF, "lhu lsb2");
    load_case(3'd1, 2'd3, 32'hFFFF_80FF, "lh lsb3");
    load_case(3'd2, 2'd3, 32'h80FF_7F00, "lw lsb3");
    load_case(3'd7, 2'd1, 32'h80FF_7F00, "unlisted f3");

    // x0 suppression
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0);
    step();
    chk("x0 RegWriteW", 64'(bus.RegWriteW), 64'd0);
    chk("x0 ResultW", 64'(bus.ResultW), 64'hCAFE_F00D);

    // Stall holds, then stall+flush makes a bubble
    drive(1'b1, 1'b1, 2'd2, 3'd0, 2'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5_0001, 32'h0);
    step();
    bus.StallW = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd9, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall ResultW", 64'(bus.ResultW), 64'hA5A5_0001);
      chk("stall RdW", 64'(bus.RdW), 64'd7);
    end
    bus.FlushW = 1'b1;
    step();
    chk("flush ValidW", 64'(bus.ValidW), 64'd0);
    chk("flush RegWriteW", 64'(bus.RegWriteW), 64'd0);
    chk("flush ResultW", 64'(bus.ResultW), 64'd0);
    bus.FlushW = 1'b0;
    bus.StallW = 1'b0;

    // Reset in the middle of a stall
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd9, 32'h1111_2222, 32'h0, 32'h0, 32'h0);
    step();
    bus.StallW = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'd3, 32'h3333_4444, 32'h0, 32'h0, 32'h0);
    step();
    chk("held ResultW", 64'(bus.ResultW), 64'h1111_2222);
    reset = 1'b1;
    step();
    chk("rst stall ValidW", 64'(bus.ValidW), 64'd0);
    chk("rst stall RegWriteW", 64'(bus.RegWriteW), 64'd0);
    chk("rst stall RdW", 64'(bus.RdW), 64'd0);
    chk("rst stall ResultW", 64'(bus.ResultW), 64'd0);
    reset = 1'b0;
    step();
    chk("stalled after rst ValidW", 64'(bus.ValidW), 64'd0);
    bus.StallW = 1'b0;
    step();
    chk("first capture ResultW", 64'(bus.ResultW), 64'h3333_4444);
    chk("first capture RdW", 64'(bus.RdW), 64'd3);

`ifdef WB_RETIRE_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 5'(i + 1), 32'(i), 32'h0, 32'h0, 32'h0);
      step();
      if (i == 4) begin
        bus.StallW = 1'b1;
        step();
        step();
        bus.StallW = 1'b0;
      end
    end
    drive(1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    chk("retire count 10", bus.RetireCnt, 64'd10);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      bus.StallW = ($urandom_range(0, 4) == 0);
      bus.FlushW = ($urandom_range(0, 9) == 0);
      drive(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      step();
    end

    reset = 1'b0;
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
